// File: rtl/move_arbiter.sv
// Cursor-movement arbiter: paces IR-remote and pushbutton direction requests
// with a step tick and drives a saturating cursor position without preemption.
module move_arbiter #(
    parameter int TICK_DIV   = 2500000,
    parameter int HOLD_TICKS = 3,
    parameter int X_MAX      = 15,
    parameter int Y_MAX      = 15,
    parameter int X_START    = 7,
    parameter int Y_START    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ir_dir_x,
    input  logic [1:0] ir_dir_y,
    input  logic       ir_valid,
    input  logic [1:0] btn_dir_x,
    input  logic [1:0] btn_dir_y,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic       step,
    output logic [1:0] owner
);

    // state | meaning
    // IDLE  | no source active, cursor parked
    // IR    | latched IR command owns the cursor until its hold expires
    // BTN   | pushbuttons own the cursor while any axis is pressed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IR   = 2'd1,
        BTN  = 2'd2
    } state_t;

    localparam int CW = $clog2(TICK_DIV);

    state_t        state, next_state;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    hold_cnt;
    logic [1:0]    ir_cmd_x, ir_cmd_y;
    logic          ir_active, btn_active;
    logic [1:0]    dir_x, dir_y;
    logic [3:0]    nxt_x, nxt_y;

    function automatic logic [3:0] move_axis(input logic [3:0] p, input logic [1:0] d,
                                             input logic [3:0] lim);
        move_axis = p;
        if (d == 2'd0 && p != 4'd0)
            move_axis = p - 4'd1;
        else if (d == 2'd1 && p < lim)
            move_axis = p + 4'd1;
    endfunction

    assign tick       = (tick_cnt == CW'(TICK_DIV - 1));
    assign ir_active  = (hold_cnt != 4'd0) && (!ir_cmd_x[1] || !ir_cmd_y[1]);
    assign btn_active = !btn_dir_x[1] || !btn_dir_y[1];

    always_comb begin
        next_state = IDLE;
        case (state)
            IR:      next_state = ir_active ? IR : (btn_active ? BTN : IDLE);
            default: next_state = btn_active ? BTN : (ir_active ? IR : IDLE);
        endcase
    end

    // The incoming owner's direction is applied on the same tick as the grant.
    always_comb begin
        dir_x = 2'd2;
        dir_y = 2'd2;
        if (next_state == IR) begin
            dir_x = ir_cmd_x;
            dir_y = ir_cmd_y;
        end else if (next_state == BTN) begin
            dir_x = btn_dir_x;
            dir_y = btn_dir_y;
        end
    end

    assign nxt_x = move_axis(pos_x, dir_x, 4'(X_MAX));
    assign nxt_y = move_axis(pos_y, dir_y, 4'(Y_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            hold_cnt <= 4'd0;
            ir_cmd_x <= 2'd2;
            ir_cmd_y <= 2'd2;
            state    <= IDLE;
            pos_x    <= 4'(X_START);
            pos_y    <= 4'(Y_START);
            step     <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

            // A fresh command reloads the hold even on a tick cycle.
            if (ir_valid) begin
                ir_cmd_x <= ir_dir_x;
                ir_cmd_y <= ir_dir_y;
                hold_cnt <= 4'(HOLD_TICKS);
            end else if (tick && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end

            if (tick) begin
                state <= next_state;
                pos_x <= nxt_x;
                pos_y <= nxt_y;
                step  <= (nxt_x != pos_x) || (nxt_y != pos_y);
            end else begin
                step  <= 1'b0;
            end
        end
    end

    assign owner = state;

endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter: directed scenarios plus random traffic, checked
// each cycle against an integer-level model of the movement rules.
module tb_move_arbiter;

    localparam int TD = 4, HT = 2, XM = 3, YM = 3, XS = 1, YS = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ir_dir_x = 2'd2, ir_dir_y = 2'd2;
    logic       ir_valid = 1'b0;
    logic [1:0] btn_dir_x = 2'd2, btn_dir_y = 2'd2;
    logic [3:0] pos_x, pos_y;
    logic       step;
    logic [1:0] owner;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int m_cnt, m_hold, m_cx, m_cy, m_owner, m_px, m_py, m_step;

    move_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT), .X_MAX(XM), .Y_MAX(YM),
                   .X_START(XS), .Y_START(YS)) dut (
        .clk(clk), .reset(reset),
        .ir_dir_x(ir_dir_x), .ir_dir_y(ir_dir_y), .ir_valid(ir_valid),
        .btn_dir_x(btn_dir_x), .btn_dir_y(btn_dir_y),
        .pos_x(pos_x), .pos_y(pos_y), .step(step), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_hold = 0; m_cx = 2; m_cy = 2;
        m_owner = 0; m_px = XS; m_py = YS; m_step = 0;
    endtask

    function automatic int apply_dir(input int p, input int d, input int lim);
        if (d == 0) return (p > 0) ? p - 1 : 0;
        if (d == 1) return (p < lim) ? p + 1 : lim;
        return p;
    endfunction

    // One rising edge of the reference: all decisions use pre-edge values.
    task automatic model_edge();
        bit tick, ir_act, btn_act;
        int nown, dx, dy, nx, ny;
        if (reset) return;
        tick    = (m_cnt == TD - 1);
        ir_act  = (m_hold > 0) && (m_cx < 2 || m_cy < 2);
        btn_act = (int'(btn_dir_x) < 2) || (int'(btn_dir_y) < 2);
        m_cnt   = tick ? 0 : m_cnt + 1;
        if (tick) begin
            if (m_owner == 1) nown = ir_act ? 1 : (btn_act ? 2 : 0);
            else              nown = btn_act ? 2 : (ir_act ? 1 : 0);
            dx = 2; dy = 2;
            if (nown == 1) begin dx = m_cx; dy = m_cy; end
            if (nown == 2) begin dx = int'(btn_dir_x); dy = int'(btn_dir_y); end
            nx = apply_dir(m_px, dx, XM);
            ny = apply_dir(m_py, dy, YM);
            m_step  = (nx != m_px || ny != m_py) ? 1 : 0;
            m_px    = nx; m_py = ny; m_owner = nown;
        end else begin
            m_step = 0;
        end
        if (ir_valid) begin
            m_cx = int'(ir_dir_x); m_cy = int'(ir_dir_y); m_hold = HT;
        end else if (tick && m_hold > 0) begin
            m_hold--;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pos_x"}, 32'(pos_x), 32'(m_px));
        chk({tag, ".pos_y"}, 32'(pos_y), 32'(m_py));
        chk({tag, ".step"},  32'(step),  32'(m_step));
        chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
    endtask

    // Inputs are changed at the falling edge, after the checks.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic idle_inputs();
        ir_valid = 1'b0; ir_dir_x = 2'd2; ir_dir_y = 2'd2;
        btn_dir_x = 2'd2; btn_dir_y = 2'd2;
    endtask

    // Reset asserted between edges; released on a falling edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1 model_reset();
        chk({tag, ".rst_pos_x"}, 32'(pos_x), XS);
        chk({tag, ".rst_pos_y"}, 32'(pos_y), YS);
        chk({tag, ".rst_step"},  32'(step), 0);
        chk({tag, ".rst_owner"}, 32'(owner), 0);
        run(2, tag);
        reset = 1'b0;
    endtask

    task automatic ir_pulse(input logic [1:0] dx, input logic [1:0] dy, input string tag);
        ir_valid = 1'b1; ir_dir_x = dx; ir_dir_y = dy;
        cyc(tag);
        ir_valid = 1'b0; ir_dir_x = 2'd2; ir_dir_y = 2'd2;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset("init");

        // IR hold: x right for exactly two ticks
        ir_pulse(2'd1, 2'd2, "irhold");
        run(3, "irhold");
        chk("irhold.t1_x", 32'(pos_x), 2);
        chk("irhold.t1_own", 32'(owner), 1);
        run(4, "irhold");
        chk("irhold.t2_x", 32'(pos_x), 3);
        run(4, "irhold");
        chk("irhold.t3_own", 32'(owner), 0);
        run(4, "irhold");

        // saturation then diagonal
        do_reset("sat");
        btn_dir_x = 2'd1;
        run(16, "sat");
        chk("sat.x", 32'(pos_x), 3);
        chk("sat.own", 32'(owner), 2);
        btn_dir_x = 2'd0; btn_dir_y = 2'd1;
        run(4, "diag");
        chk("diag.x", 32'(pos_x), 2);
        chk("diag.y", 32'(pos_y), 2);
        chk("diag.step", 32'(step), 1);
        idle_inputs();
        run(4, "diag");

        // no preemption
        do_reset("nopre");
        ir_pulse(2'd2, 2'd0, "nopre");
        run(3, "nopre");
        btn_dir_x = 2'd1;
        run(4, "nopre");
        chk("nopre.own_ir", 32'(owner), 1);
        chk("nopre.y", 32'(pos_y), 0);
        run(4, "nopre");
        chk("nopre.own_btn", 32'(owner), 2);
        chk("nopre.x", 32'(pos_x), 2);
        idle_inputs();
        run(4, "nopre");

        // simultaneous request: buttons win, IR used afterwards while held
        do_reset("simul");
        btn_dir_y = 2'd1;
        ir_pulse(2'd0, 2'd2, "simul");
        run(3, "simul");
        chk("simul.own", 32'(owner), 2);
        chk("simul.y", 32'(pos_y), 2);
        chk("simul.x", 32'(pos_x), 1);
        btn_dir_y = 2'd2;
        run(4, "simul");
        chk("simul.ir_own", 32'(owner), 1);
        chk("simul.ir_x", 32'(pos_x), 0);
        run(8, "simul");

        // ir_valid on the tick cycle
        do_reset("ontick");
        ir_pulse(2'd1, 2'd2, "ontick");
        run(6, "ontick");
        ir_pulse(2'd0, 2'd2, "ontick");
        chk("ontick.old_x", 32'(pos_x), 3);
        run(4, "ontick");
        chk("ontick.new1_x", 32'(pos_x), 2);
        run(4, "ontick");
        chk("ontick.new2_x", 32'(pos_x), 1);
        chk("ontick.new2_own", 32'(owner), 1);
        run(4, "ontick");
        chk("ontick.end_own", 32'(owner), 0);

        // reset mid-operation at owner=IR, pos=(3,0)
        do_reset("midrst");
        ir_pulse(2'd1, 2'd0, "midrst");
        run(7, "midrst");
        chk("midrst.pre_x", 32'(pos_x), 3);
        chk("midrst.pre_y", 32'(pos_y), 0);
        chk("midrst.pre_own", 32'(owner), 1);
        run(2, "midrst");
        do_reset("midrst");
        run(12, "midrst_idle");
        chk("midrst.idle_x", 32'(pos_x), 1);
        do_reset("firsttick");
        btn_dir_x = 2'd1;
        run(3, "firsttick");
        chk("firsttick.before", 32'(pos_x), 1);
        cyc("firsttick");
        chk("firsttick.at", 32'(pos_x), 2);
        idle_inputs();

        // random traffic
        do_reset("rand");
        for (int i = 0; i < 3000; i++) begin
            ir_valid = ($urandom_range(0, 9) == 0);
            ir_dir_x = 2'($urandom_range(0, 3));
            ir_dir_y = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) begin
                btn_dir_x = 2'($urandom_range(0, 3));
                btn_dir_y = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) begin
                btn_dir_x = 2'd2; btn_dir_y = 2'd3;
            end
            cyc("rand");
            if (i % 997 == 996) do_reset("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Cursor-movement controller for the design project. Shares one cursor position register between two direction sources: the decoded IR remote command (pulse-qualified, no release indication) and the on-board pushbuttons (level). It paces movement with an internal step tick and arbitrates ownership without preemption. It drives the saturating cursor position, a one-cycle step strobe and the current owner.

## Interface
- TICK_DIV, 2500000: clk cycles per step tick (50 MHz → 20 Hz); ≥2
- HOLD_TICKS, 3: step ticks an IR command stays active after its last ir_valid; 1..15
- X_MAX, 15: upper bound of pos_x; ≤15
- Y_MAX, 15: upper bound of pos_y; ≤15
- X_START, 7: reset value of pos_x
- Y_START, 7: reset value of pos_y

- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- ir_dir_x  in  2  IR x direction: 0 = left/neg, 1 = right/pos, 2 or 3 = none
- ir_dir_y  in  2  IR y direction: 0 = up/neg, 1 = down/pos, 2 or 3 = none
- ir_valid  in  1  one-cycle strobe, synchronous to clk: new IR command on ir_dir_*
- btn_dir_x  in  2  button x direction, level, same encoding
- btn_dir_y  in  2  button y direction, level, same encoding
- pos_x  out  4  cursor x, 0..X_MAX
- pos_y  out  4  cursor y, 0..Y_MAX
- step  out  1  one-cycle pulse: position changed
- owner  out  2  0 = IDLE, 1 = IR, 2 = BTN (3 unused)

## Operation
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick is 1 for the single cycle where the count is TICK_DIV-1.
- IR latch: on ir_valid, ir_cmd_x/y <= ir_dir_x/y and hold_cnt <= HOLD_TICKS.
- On a tick without ir_valid, hold_cnt decrements if it is nonzero.
- If ir_valid and tick occur in the same cycle, the reload wins and there is no decrement.
- ir_active = (hold_cnt != 0) and (ir_cmd_x < 2 or ir_cmd_y < 2).
- btn_active = (btn_dir_x < 2 or btn_dir_y < 2).
- FSM states are IDLE, IR and BTN, and change only on tick. All decisions use register values from before the tick edge.
  - IDLE: btn_active → BTN; else ir_active → IR; else IDLE. Buttons win a simultaneous request.
  - IR: ir_active → IR; else btn_active → BTN; else IDLE.
  - BTN: btn_active → BTN; else ir_active → IR; else IDLE.
- No preemption: the owner keeps the grant until its own source goes inactive.
- Move: on the same tick, the direction of the next state's source is applied; IDLE moves nothing.
  - Per axis, direction 0 decrements saturating at 0 and direction 1 increments saturating at X_MAX/Y_MAX.
  - Directions 2 and 3 leave the axis unchanged.
  - Both axes may move on one tick (diagonal).
- step: registered. It is 1 for the cycle after a tick in which pos_x or pos_y actually changed, else 0. A saturated move produces no step.
- owner = FSM state register.

## Timing
- Reset (async, any time including mid-tick):
  - pos_x = X_START, pos_y = Y_START, step = 0, owner = 0
  - tick counter = 0, hold_cnt = 0, ir_cmd_x/y = 2
- After reset deasserts, the first tick occurs TICK_DIV cycles later.
- A command latched by ir_valid takes effect at the first tick strictly after the ir_valid cycle.
- A single ir_valid yields exactly HOLD_TICKS step ticks of IR movement, assuming no saturation and no competing owner. The owner returns to IDLE on tick HOLD_TICKS+1.
- If BTN holds the grant, IR hold time elapses and is not deferred; an expired IR command is lost.
- pos_x, pos_y and owner update on the clock edge ending the tick cycle. step is high during the following cycle, aligned with the new position.
- A button change between ticks is ignored; only the level sampled at the tick matters.
- No input synchronizers are inside this block: buttons arrive debounced and synchronized, and ir_valid arrives already in the clk domain.

## Test plan
All cases use TICK_DIV=4, HOLD_TICKS=2, X_MAX=Y_MAX=3, X_START=Y_START=1.
- IR hold: one ir_valid with ir_dir_x=1, ir_dir_y=2.
  - pos_x goes 1→2→3 on two consecutive ticks, with step after each.
  - owner is IR for 2 ticks, then 0.
- Saturation and diagonal:
  - btn_dir_x=1 held 4 ticks: pos_x 1→2→3→3→3; step only on the first two; owner stays 2.
  - Then btn_dir_x=0, btn_dir_y=1: pos changes (3,1)→(2,2).
- No preemption: IR owns (ir_dir_y=0), then btn_dir_x=1 is asserted.
  - owner stays 1 until hold expires (pos_y 1→0).
  - On the next tick owner goes to 2 and pos_x increments on that same tick.
- Simultaneous request: from IDLE, ir_valid (ir_dir_x=0) and btn_dir_y=1 both present at the tick.
  - owner goes to 2, pos_y increments, pos_x unchanged.
  - After the buttons release, the IR command is used only if hold_cnt is still nonzero.
- ir_valid on the tick cycle:
  - The old command moves on that tick.
  - hold_cnt reloads to 2 (no decrement).
  - The new command moves on the next 2 ticks.
- Reset mid-operation: assert reset while owner=1 and pos=(3,0).
  - Outputs return immediately to pos=(1,1), owner=0, step=0.
  - No movement occurs until a new request, and the first tick comes 4 cycles after deassert.
